hilo_muldiv_seq: RTL and testbench

- Multi-cycle multiply/divide sequencer that owns every write into the HI/LO register pair.
- Sits beside the EX stage. Accepts one MULT/DIV-class operation, runs a 32-iteration shift-add or restoring-divide loop, and stalls the pipeline meanwhile.
- Issues a single-cycle write of the 64-bit result to HI/LO; the caller may annul the operation before that write.

---
 rtl/hilo_muldiv_seq_if.sv | 28 ++
 rtl/hilo_muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_hilo_muldiv_seq.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_seq_if.sv
// HI/LO multiply/divide sequencer bus: request side from EX,
// result/stall side back to the pipeline and HI/LO file.
interface hilo_muldiv_seq_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [31:0] hi_cur_i;
  logic [31:0] lo_cur_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        hilo_we_o;
  logic        stall_req_o;
  logic        busy_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i,
    output annul_i, hi_cur_i, lo_cur_i,
    input  hi_o, lo_o, hilo_we_o, stall_req_o, busy_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i,
    input  annul_i, hi_cur_i, lo_cur_i,
    output hi_o, lo_o, hilo_we_o, stall_req_o, busy_o
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO writes.
// Optional MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module hilo_muldiv_seq #(
  parameter int ITER = 32
) (
  input logic clk,
  input logic rst,
  hilo_muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DIVZERO,
    DONE
  } state_t;

  state_t state, state_n;

  logic [4:0]  cnt;
  logic [31:0] a_mag, b_mag;
  logic [63:0] p, p_n;
  logic [31:0] hi_q, lo_q;
  logic        is_div, neg_q, neg_r;

  logic        op_sgn, op_div, s1, s2;
  logic        legal, accept, last, stall;
  logic [31:0] mag1, mag2;

  logic [32:0] rem_s, diff, sum;
  logic [63:0] prod, res;
  logic [31:0] quo, rem;

`ifdef MULDIV_MADD_EN
  logic is_acc, is_sub;
  assign legal = 1'b1;
`else
  logic unused_cur;
  assign unused_cur = ^{bus.hi_cur_i, bus.lo_cur_i};
  assign legal = ~bus.op_i[2];
`endif

  assign op_sgn = ~bus.op_i[0];
  assign op_div = (bus.op_i[2:1] == 2'b01);
  assign s1     = op_sgn & bus.opdata1_i[31];
  assign s2     = op_sgn & bus.opdata2_i[31];
  assign mag1   = s1 ? 32'd0 - bus.opdata1_i : bus.opdata1_i;
  assign mag2   = s2 ? 32'd0 - bus.opdata2_i : bus.opdata2_i;
  assign accept = (state == IDLE) & bus.start_i
                & legal & ~bus.annul_i;
  assign last   = (cnt == 5'(ITER - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stall   = 1'b1;
          state_n = (op_div && bus.opdata2_i == 32'd0)
                  ? DIVZERO : RUN;
        end
      end
      RUN: begin
        stall = 1'b1;
        if (bus.annul_i) state_n = IDLE;
        else if (last)   state_n = DONE;
      end
      DIVZERO: begin
        stall   = 1'b1;
        state_n = bus.annul_i ? IDLE : DONE;
      end
      DONE: state_n = IDLE;
    endcase
  end

  // Shared {rem,quo} / {acc,multiplier} shift register step
  always_comb begin
    rem_s = {p[63:32], p[31]};
    diff  = rem_s - {1'b0, b_mag};
    sum   = {1'b0, p[63:32]}
          + (p[0] ? {1'b0, a_mag} : 33'd0);
    if (is_div) begin
      if (diff[32]) p_n = {rem_s[31:0], p[30:0], 1'b0};
      else          p_n = {diff[31:0], p[30:0], 1'b1};
    end else begin
      p_n = {sum, p[31:1]};
    end
  end

  always_comb begin
    prod = neg_q ? 64'd0 - p_n : p_n;
    quo  = neg_q ? 32'd0 - p_n[31:0] : p_n[31:0];
    rem  = neg_r ? 32'd0 - p_n[63:32] : p_n[63:32];
    res  = is_div ? {rem, quo} : prod;
`ifdef MULDIV_MADD_EN
    if (is_acc) begin
      if (is_sub)
        res = {bus.hi_cur_i, bus.lo_cur_i} - prod;
      else
        res = {bus.hi_cur_i, bus.lo_cur_i} + prod;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_mag  <= '0;
      b_mag  <= '0;
      p      <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`ifdef MULDIV_MADD_EN
      is_acc <= 1'b0;
      is_sub <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            cnt    <= '0;
            a_mag  <= mag1;
            b_mag  <= mag2;
            is_div <= op_div;
            neg_q  <= s1 ^ s2;
            neg_r  <= s1;
            p      <= {32'd0, op_div ? mag1 : mag2};
`ifdef MULDIV_MADD_EN
            is_acc <= bus.op_i[2];
            is_sub <= bus.op_i[2] & bus.op_i[1];
`endif
          end
        end
        RUN: begin
          if (!bus.annul_i) begin
            p   <= p_n;
            cnt <= cnt + 5'd1;
            if (last) begin
              hi_q <= res[63:32];
              lo_q <= res[31:0];
            end
          end
        end
        DIVZERO: begin
          if (!bus.annul_i) begin
            hi_q <= '0;
            lo_q <= '0;
          end
        end
        DONE: ;
      endcase
    end
  end

  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;
  assign bus.hilo_we_o   = (state == DONE);
  assign bus.stall_req_o = stall;
  assign bus.busy_o      = (state != IDLE);

endmodule

// File: tb/tb_hilo_muldiv_seq.sv
// Self-checking bench for hilo_muldiv_seq: directed cases
// plus randomized traffic against a countdown reference model.
module tb_hilo_muldiv_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hilo_muldiv_seq_if bus();

  hilo_muldiv_seq #(.ITER(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40)
        $display("FAIL %s act=%h exp=%h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  function automatic bit legal_op(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
    return 1'b1;
`else
    return !op[2];
`endif
  endfunction

  function automatic logic [63:0] model_res(
    input logic [2:0]  op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] cur);
    int ia, ib;
    longint sa, sb, q, r;
    logic [63:0] pr;
    ia = a;
    ib = b;
    sa = ia;
    sb = ib;
    if (op[2:1] == 2'b01) begin
      if (b == 32'd0) return 64'd0;
      if (!op[0]) begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      return {a % b, a / b};
    end
    if (!op[0]) pr = sa * sb;
    else        pr = {32'd0, a} * {32'd0, b};
    if (op[2]) pr = op[1] ? cur - pr : cur + pr;
    return pr;
  endfunction

  // Reference model: cycles remaining until the write cycle
  int          remain;
  bit          armed;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  initial begin
    bit exp_stall;
    armed  = 1'b0;
    remain = -1;
    m_hi   = '0;
    m_lo   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (armed) begin
        exp_stall = (remain > 0) ||
          (remain < 0 && bus.start_i &&
           legal_op(bus.op_i) && !bus.annul_i);
        chk("m_busy", 64'(bus.busy_o), 64'(remain >= 0));
        chk("m_we", 64'(bus.hilo_we_o), 64'(remain == 0));
        chk("m_stall", 64'(bus.stall_req_o), 64'(exp_stall));
        chk("m_hilo", {bus.hi_o, bus.lo_o}, {m_hi, m_lo});
      end
      @(posedge clk);
      if (rst) begin
        armed  = 1'b1;
        remain = -1;
        m_hi   = '0;
        m_lo   = '0;
      end else if (remain < 0) begin
        if (bus.start_i && legal_op(bus.op_i) && !bus.annul_i) begin
          m_op = bus.op_i;
          m_a  = bus.opdata1_i;
          m_b  = bus.opdata2_i;
          remain = (m_op[2:1] == 2'b01 && m_b == 32'd0) ? 1 : 32;
        end
      end else if (remain == 0) begin
        remain = -1;
      end else if (bus.annul_i) begin
        remain = -1;
      end else begin
        remain--;
        if (remain == 0)
          {m_hi, m_lo} = model_res(m_op, m_a, m_b,
                                   {bus.hi_cur_i, bus.lo_cur_i});
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input string nm,
                       input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] eh,
                       input logic [31:0] el,
                       input int lat,
                       input bit hold);
    int seen;
    bit stall_bad;
    seen = -1;
    stall_bad = 1'b0;
    bus.start_i   = 1'b1;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    for (int c = 0; c < 45; c++) begin
      #3;
      if (bus.hilo_we_o) begin
        seen = c;
        chk({nm, "_hi"}, 64'(bus.hi_o), 64'(eh));
        chk({nm, "_lo"}, 64'(bus.lo_o), 64'(el));
        chk({nm, "_done_stall"}, 64'(bus.stall_req_o), 64'd0);
        break;
      end
      if (!bus.stall_req_o) stall_bad = 1'b1;
      @(negedge clk);
      if (hold) begin
        bus.op_i      = 3'($urandom_range(0, 3));
        bus.opdata1_i = $urandom;
        bus.opdata2_i = $urandom;
      end else begin
        bus.start_i = 1'b0;
      end
    end
    bus.start_i = 1'b0;
    chk({nm, "_lat"}, 64'(seen), 64'(lat));
    chk({nm, "_stall"}, 64'(stall_bad), 64'd0);
    @(negedge clk);
    #3;
    chk({nm, "_idle"}, 64'(bus.busy_o), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    int wes;
    checks   = 0;
    failures = 0;
    rst           = 1'b1;
    bus.start_i   = 1'b0;
    bus.op_i      = '0;
    bus.opdata1_i = '0;
    bus.opdata2_i = '0;
    bus.annul_i   = 1'b0;
    bus.hi_cur_i  = '0;
    bus.lo_cur_i  = '0;

    chk("pin_divu", model_res(3'd3, 32'd100, 32'd7, 64'd0),
        {32'd2, 32'd14});
    chk("pin_div", model_res(3'd2, 32'hFFFF_FFF9, 32'd2, 64'd0),
        64'hFFFF_FFFF_FFFF_FFFD);
    chk("pin_mult", model_res(3'd0, 32'hFFFF_FFFD, 32'd5, 64'd0),
        64'hFFFF_FFFF_FFFF_FFF1);
    chk("pin_msub", model_res(3'd6, 32'd1, 32'd1, 64'd0),
        64'hFFFF_FFFF_FFFF_FFFF);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_we", 64'(bus.hilo_we_o), 64'd0);
    @(negedge clk);

    do_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 33, 0);
    do_op("div_zero", 3'd2, 32'd5, 32'd0, 32'd0, 32'd0, 2, 0);
    do_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd5,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 33, 0);
    do_op("multu_hold", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'd1, 33, 1);

    // annul in cycle 10 of a MULT
    bus.start_i   = 1'b1;
    bus.op_i      = 3'd0;
    bus.opdata1_i = 32'd7;
    bus.opdata2_i = 32'd9;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (9) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    #3;
    chk("annul_stall", 64'(bus.stall_req_o), 64'd0);
    chk("annul_busy", 64'(bus.busy_o), 64'd0);
    wes = 0;
    repeat (30) begin
      @(negedge clk);
      #3;
      if (bus.hilo_we_o) wes++;
    end
    chk("annul_nowrite", 64'(wes), 64'd0);
    chk("annul_hold", {bus.hi_o, bus.lo_o},
        64'hFFFF_FFFE_0000_0001);
    @(negedge clk);

    // reset in cycle 20 of a MULT
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("rstmid_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    chk("rstmid_busy", 64'(bus.busy_o), 64'd0);
    chk("rstmid_stall", 64'(bus.stall_req_o), 64'd0);
    @(negedge clk);

`ifdef MULDIV_MADD_EN
    bus.hi_cur_i = 32'd0;
    bus.lo_cur_i = 32'hFFFF_FFFF;
    do_op("maddu", 3'd5, 32'd1, 32'd1, 32'd1, 32'd0, 33, 0);
    bus.lo_cur_i = 32'd0;
    do_op("msub", 3'd6, 32'd1, 32'd1,
          32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
`else
    bus.start_i   = 1'b1;
    bus.op_i      = 3'd4;
    bus.opdata1_i = 32'd3;
    bus.opdata2_i = 32'd3;
    #3;
    chk("illegal_stall", 64'(bus.stall_req_o), 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    #3;
    chk("illegal_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
`endif

    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom % 400) == 0;
      bus.start_i   = ($urandom % 3) == 0;
      bus.op_i      = 3'($urandom);
      bus.opdata1_i = pick();
      bus.opdata2_i = pick();
      bus.annul_i   = ($urandom % 80) == 0;
      bus.hi_cur_i  = $urandom;
      bus.lo_cur_i  = $urandom;
      @(negedge clk);
    end
    rst         = 1'b0;
    bus.start_i = 1'b0;
    bus.annul_i = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
